// File: rtl/proc_io_pkg.sv
// Shared CSR map and address-decode helpers for the TinyRV1 CSR I/O unit.
package proc_io_pkg;

  localparam logic [11:0] CSR_OUT_BASE   = 12'h7C0;
  localparam logic [11:0] CSR_IN_BASE    = 12'hFC0;
  localparam logic [11:0] CSR_MCYCLE     = 12'hC00;
  localparam logic [11:0] CSR_MCYCLE_H   = 12'hC80;
  localparam logic [11:0] CSR_MINSTRET   = 12'hC02;
  localparam logic [11:0] CSR_MINSTRET_H = 12'hC82;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_OUT,
    RD_IN,
    RD_MCYCLE,
    RD_MCYCLE_H,
    RD_MINSTRET,
    RD_MINSTRET_H
  } rd_src_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } csr_idx_t;

  // A 16-entry window at base; only the first n entries are populated.
  function automatic csr_idx_t decode_idx(input logic [11:0] addr, input logic [11:0] base,
                                          input int unsigned n);
    csr_idx_t r;
    r.idx   = addr[3:0];
    r.valid = (addr[11:4] == base[11:4]) && ({28'd0, addr[3:0]} < n);
    return r;
  endfunction

  function automatic csr_idx_t is_out(input logic [11:0] addr, input int unsigned n);
    return decode_idx(addr, CSR_OUT_BASE, n);
  endfunction

  function automatic csr_idx_t is_in(input logic [11:0] addr, input int unsigned n);
    return decode_idx(addr, CSR_IN_BASE, n);
  endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-flop synchroniser for one asynchronous input channel.
module io_sync #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned s = 1; s < STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/proc_io_csr.sv
// TinyRV1 CSR I/O unit: output registers, synchronised inputs, mcycle/minstret.
module proc_io_csr
  import proc_io_pkg::*;
#(
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_val,
  input  logic                  csr_wen,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_err,
  input  logic                  retire,
  input  logic [NUM_IN*32-1:0]  in_data,
  output logic [NUM_OUT*32-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_strobe
);

  logic [CNT_W-1:0]   mcycle_q, mcycle_d;
  logic [CNT_W-1:0]   minstret_q, minstret_d;
  logic [31:0]        out_q [NUM_OUT];
  logic [31:0]        out_d [NUM_OUT];
  logic [NUM_OUT-1:0] strobe_q, strobe_d;
  logic               err_q, err_d;
  logic [31:0]        in_sync [NUM_IN];

  csr_idx_t out_hit, in_hit;
  rd_src_e  rd_src;
  logic     rd_en, wr_en, legal;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_sync #(.W(32), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (in_data[32*g +: 32]),
      .q   (in_sync[g])
    );
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_data[32*g +: 32] = out_q[g];
  end

  always_comb begin
    out_hit = is_out(csr_addr, NUM_OUT);
    in_hit  = is_in(csr_addr, NUM_IN);
    rd_en   = csr_val & ~csr_wen;
    wr_en   = csr_val & csr_wen;
    rd_src  = RD_NONE;
    if (out_hit.valid) begin
      rd_src = RD_OUT;
    end else if (in_hit.valid) begin
      rd_src = RD_IN;
    end else begin
      case (csr_addr)
        CSR_MCYCLE:     rd_src = RD_MCYCLE;
        CSR_MCYCLE_H:   rd_src = RD_MCYCLE_H;
        CSR_MINSTRET:   rd_src = RD_MINSTRET;
        CSR_MINSTRET_H: rd_src = RD_MINSTRET_H;
        default:        rd_src = RD_NONE;
      endcase
    end
    // Only output registers are writable; every mapped address is readable.
    legal = wr_en ? out_hit.valid : (rd_src != RD_NONE);
    err_d = csr_val & ~legal;
  end

  // Read mux sees only registered state, so a same-cycle write or increment is not visible.
  always_comb begin
    csr_rdata = '0;
    if (rd_en) begin
      case (rd_src)
        RD_OUT: begin
          for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (out_hit.idx == 4'(i)) csr_rdata = out_q[i];
          end
        end
        RD_IN: begin
          for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_hit.idx == 4'(i)) csr_rdata = in_sync[i];
          end
        end
        RD_MCYCLE:     csr_rdata = mcycle_q[31:0];
        RD_MCYCLE_H:   csr_rdata = 32'(mcycle_q >> 32);
        RD_MINSTRET:   csr_rdata = minstret_q[31:0];
        RD_MINSTRET_H: csr_rdata = 32'(minstret_q >> 32);
        default:       csr_rdata = '0;
      endcase
    end
  end

  always_comb begin
    mcycle_d   = mcycle_q + CNT_W'(1);
    minstret_d = retire ? minstret_q + CNT_W'(1) : minstret_q;
    strobe_d   = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      out_d[i] = out_q[i];
      if (wr_en && out_hit.valid && (out_hit.idx == 4'(i))) begin
        out_d[i]    = csr_wdata;
        strobe_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      strobe_q   <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  assign out_strobe = strobe_q;
  assign csr_err    = err_q;

endmodule

// File: tb/tb_proc_io_csr.sv
// Self-checking bench for proc_io_csr against a behavioural model of the CSR map.
module tb_proc_io_csr;

  localparam int NUM_IN  = 3;
  localparam int NUM_OUT = 3;
  localparam int SYNC    = 2;
  localparam int CNT_W   = 64;
  localparam longint unsigned CMASK = (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                    : ((64'd1 << CNT_W) - 64'd1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  csr_val, csr_wen, retire, csr_err;
  logic [11:0]           csr_addr;
  logic [31:0]           csr_wdata, csr_rdata;
  logic [NUM_IN*32-1:0]  in_data;
  logic [NUM_OUT*32-1:0] out_data;
  logic [NUM_OUT-1:0]    out_strobe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proc_io_csr #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_val    (csr_val),
    .csr_wen    (csr_wen),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_err    (csr_err),
    .retire     (retire),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_strobe (out_strobe)
  );

  // ---------------- reference model ----------------
  longint unsigned      m_cyc, m_ret, force_val;
  logic [31:0]          m_out [NUM_OUT];
  logic [NUM_OUT-1:0]   m_strobe;
  logic                 m_err;
  logic [NUM_IN*32-1:0] m_hist [$];
  int                   force_seq = 0;
  int                   seen_seq  = 0;

  function automatic bit in_out_range(input logic [11:0] a);
    int ai = int'(a);
    return (ai >= 'h7C0) && (ai < 'h7C0 + NUM_OUT);
  endfunction

  function automatic bit in_in_range(input logic [11:0] a);
    int ai = int'(a);
    return (ai >= 'hFC0) && (ai < 'hFC0 + NUM_IN);
  endfunction

  function automatic bit m_legal(input logic wen, input logic [11:0] a);
    if (wen) return in_out_range(a);
    return in_out_range(a) || in_in_range(a) || a == 12'hC00 || a == 12'hC80 ||
           a == 12'hC02 || a == 12'hC82;
  endfunction

  function automatic logic [31:0] m_read(input logic val, input logic wen, input logic [11:0] a);
    logic [NUM_IN*32-1:0] vis;
    longint unsigned      c;
    if (!(val === 1'b1 && wen === 1'b0)) return 32'd0;
    if (in_out_range(a)) return m_out[int'(a) - 'h7C0];
    if (in_in_range(a)) begin
      vis = (m_hist.size() >= SYNC) ? m_hist[0] : '0;
      return vis[32*(int'(a) - 'hFC0) +: 32];
    end
    case (a)
      12'hC00: begin c = m_cyc; return c[31:0]; end
      12'hC80: begin c = m_cyc >> 32; return c[31:0]; end
      12'hC02: begin c = m_ret; return c[31:0]; end
      12'hC82: begin c = m_ret >> 32; return c[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [NUM_OUT*32-1:0] m_out_flat();
    logic [NUM_OUT*32-1:0] r;
    for (int i = 0; i < NUM_OUT; i++) r[32*i +: 32] = m_out[i];
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc    <= 0;
      m_ret    <= 0;
      m_strobe <= '0;
      m_err    <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) m_out[i] <= '0;
      m_hist.delete();
    end else begin
      if (force_seq != seen_seq) begin
        m_cyc    <= (force_val + 1) & CMASK;
        seen_seq <= force_seq;
      end else begin
        m_cyc <= (m_cyc + 1) & CMASK;
      end
      if (retire) m_ret <= (m_ret + 1) & CMASK;
      m_hist.push_back(in_data);
      if (m_hist.size() > SYNC) void'(m_hist.pop_front());
      m_strobe <= '0;
      m_err    <= csr_val && !m_legal(csr_wen, csr_addr);
      if (csr_val && csr_wen && m_legal(1'b1, csr_addr)) begin
        m_out[int'(csr_addr) - 'h7C0]    <= csr_wdata;
        m_strobe[int'(csr_addr) - 'h7C0] <= 1'b1;
      end
    end
  end

  task automatic idle();
    csr_val   = 1'b0;
    csr_wen   = 1'b0;
    csr_addr  = 12'h000;
    csr_wdata = 32'd0;
    retire    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; idle(); in_data = '0;
    csr_val = 1'b1; csr_addr = 12'hC00;
    repeat (3) @(negedge clk);
    #1;
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", out_data); end
    total++; if (out_strobe !== '0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", out_strobe); end
    total++; if (csr_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", csr_err); end
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL reset_mcycle got=%h exp=0", csr_rdata); end
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (csr_rdata !== 32'd1) begin bad++; $display("FAIL release_mcycle got=%h exp=1", csr_rdata); end
    total++; if (csr_rdata !== m_read(csr_val, csr_wen, csr_addr)) begin
      bad++; $display("FAIL release_model got=%h exp=%h", csr_rdata, m_read(csr_val, csr_wen, csr_addr)); end
  endtask

  task automatic test_write();
    @(negedge clk); idle(); csr_val = 1'b1; csr_addr = 12'h7C1; #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL wr_old_read got=%h exp=0", csr_rdata); end
    @(negedge clk); csr_wen = 1'b1; csr_wdata = 32'hDEADBEEF; #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL wr_cycle_rdata got=%h exp=0", csr_rdata); end
    total++; if (out_data[63:32] !== 32'd0) begin bad++; $display("FAIL wr_before_edge got=%h exp=0", out_data[63:32]); end
    @(negedge clk); csr_wen = 1'b0; #1;
    total++; if (out_data[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_out1 got=%h exp=deadbeef", out_data[63:32]); end
    total++; if (out_strobe !== 3'b010) begin bad++; $display("FAIL wr_strobe got=%b exp=010", out_strobe); end
    total++; if (csr_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_readback got=%h exp=deadbeef", csr_rdata); end
    @(negedge clk); idle(); #1;
    total++; if (out_strobe !== 3'b000) begin bad++; $display("FAIL wr_strobe_drop got=%b exp=000", out_strobe); end
    total++; if (csr_err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", csr_err); end
  endtask

  task automatic test_sync();
    @(negedge clk); idle(); in_data = '0;
    repeat (SYNC + 1) @(negedge clk);
    in_data[95:64] = 32'h1234; csr_val = 1'b1; csr_addr = 12'hFC2; #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL sync_e0 got=%h exp=0", csr_rdata); end
    @(negedge clk); #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL sync_e1 got=%h exp=0", csr_rdata); end
    @(negedge clk); #1;
    total++; if (csr_rdata !== 32'h1234) begin bad++; $display("FAIL sync_e2 got=%h exp=1234", csr_rdata); end
    total++; if (csr_rdata !== m_read(csr_val, csr_wen, csr_addr)) begin
      bad++; $display("FAIL sync_model got=%h exp=%h", csr_rdata, m_read(csr_val, csr_wen, csr_addr)); end
  endtask

  task automatic test_illegal();
    logic [12:0] ops [5] = '{{1'b1, 12'hC00}, {1'b0, 12'h7C5}, {1'b1, 12'hFC0},
                             {1'b0, 12'h123}, {1'b1, 12'h7C3}};
    logic [NUM_OUT*32-1:0] exp_out;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); idle();
      exp_out = m_out_flat();
      csr_val = 1'b1; csr_wen = ops[k][12]; csr_addr = ops[k][11:0]; csr_wdata = 32'hA5A5_0000 + 32'(k); #1;
      total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL ill_rdata k=%0d got=%h exp=0", k, csr_rdata); end
      @(negedge clk); idle(); csr_val = 1'b1; csr_addr = 12'hC00; #1;
      total++; if (csr_err !== 1'b1) begin bad++; $display("FAIL ill_err k=%0d got=%b exp=1", k, csr_err); end
      total++; if (out_data !== exp_out) begin bad++; $display("FAIL ill_out k=%0d got=%h exp=%h", k, out_data, exp_out); end
      total++; if (out_strobe !== 3'b000) begin bad++; $display("FAIL ill_strobe k=%0d got=%b exp=000", k, out_strobe); end
      total++; if (csr_rdata !== m_read(csr_val, csr_wen, csr_addr)) begin
        bad++; $display("FAIL ill_mcycle k=%0d got=%h exp=%h", k, csr_rdata, m_read(csr_val, csr_wen, csr_addr)); end
    end
    @(negedge clk); idle(); #1;
    total++; if (csr_err !== 1'b0) begin bad++; $display("FAIL ill_err_clear got=%b exp=0", csr_err); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle(); csr_val = 1'b1; csr_wen = 1'b1; csr_addr = 12'h7C0; csr_wdata = 32'h1111_AAAA;
    @(negedge clk); csr_wdata = 32'h2222_BBBB; #1;
    total++; if (out_strobe !== 3'b001) begin bad++; $display("FAIL b2b_strobe1 got=%b exp=001", out_strobe); end
    total++; if (out_data[31:0] !== 32'h1111_AAAA) begin bad++; $display("FAIL b2b_out1 got=%h exp=1111aaaa", out_data[31:0]); end
    @(negedge clk); idle(); #1;
    total++; if (out_strobe !== 3'b001) begin bad++; $display("FAIL b2b_strobe2 got=%b exp=001", out_strobe); end
    total++; if (out_data[31:0] !== 32'h2222_BBBB) begin bad++; $display("FAIL b2b_out2 got=%h exp=2222bbbb", out_data[31:0]); end
    @(negedge clk); #1;
    total++; if (out_strobe !== 3'b000) begin bad++; $display("FAIL b2b_strobe3 got=%b exp=000", out_strobe); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [16] = '{12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'h7C4, 12'hFC0, 12'hFC1, 12'hFC2,
                               12'hFC3, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC01, 12'h123, 12'h7CF};
    logic [31:0] exp_rd;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      csr_val   = ($urandom_range(0, 9) < 7);
      csr_wen   = $urandom_range(0, 1) == 1;
      csr_addr  = addrs[$urandom_range(0, 15)];
      csr_wdata = $urandom;
      retire    = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) in_data[32*$urandom_range(0, NUM_IN-1) +: 32] = $urandom;
      #1;
      exp_rd = m_read(csr_val, csr_wen, csr_addr);
      total++; if (csr_rdata !== exp_rd) begin
        bad++; $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, csr_addr, csr_rdata, exp_rd); end
      total++; if (out_data !== m_out_flat()) begin
        bad++; $display("FAIL rand_out n=%0d got=%h exp=%h", n, out_data, m_out_flat()); end
      total++; if (out_strobe !== m_strobe) begin
        bad++; $display("FAIL rand_strobe n=%0d got=%b exp=%b", n, out_strobe, m_strobe); end
      total++; if (csr_err !== m_err) begin
        bad++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, csr_err, m_err); end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk); idle();
    force dut.mcycle_q = 64'h0000_0000_FFFF_FFFF;
    force_val = 64'h0000_0000_FFFF_FFFF; force_seq++;
    csr_val = 1'b1; csr_addr = 12'hC00; #1;
    total++; if (csr_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap32_lo_pre got=%h exp=ffffffff", csr_rdata); end
    release dut.mcycle_q;
    @(negedge clk); #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL wrap32_lo got=%h exp=0", csr_rdata); end
    csr_addr = 12'hC80; #1;
    total++; if (csr_rdata !== 32'd1) begin bad++; $display("FAIL wrap32_hi got=%h exp=1", csr_rdata); end
    total++; if (csr_rdata !== m_read(csr_val, csr_wen, csr_addr)) begin
      bad++; $display("FAIL wrap32_model got=%h exp=%h", csr_rdata, m_read(csr_val, csr_wen, csr_addr)); end
    @(negedge clk);
    force dut.mcycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    force_val = 64'hFFFF_FFFF_FFFF_FFFF; force_seq++;
    csr_addr = 12'hC80; #1;
    total++; if (csr_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap64_hi_pre got=%h exp=ffffffff", csr_rdata); end
    release dut.mcycle_q;
    @(negedge clk); #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL wrap64_hi got=%h exp=0", csr_rdata); end
    csr_addr = 12'hC00; #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL wrap64_lo got=%h exp=0", csr_rdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle(); csr_val = 1'b1; csr_wen = 1'b1; csr_addr = 12'h7C2; csr_wdata = 32'h55;
    @(negedge clk); idle(); csr_val = 1'b1; csr_wen = 1'b1; csr_addr = 12'h7C7; #1;
    total++; if (out_strobe !== 3'b100) begin bad++; $display("FAIL mid_strobe_pre got=%b exp=100", out_strobe); end
    @(negedge clk); idle(); #1;
    total++; if (csr_err !== 1'b1) begin bad++; $display("FAIL mid_err_pre got=%b exp=1", csr_err); end
    rst = 1'b0; #1;
    total++; if (csr_err !== 1'b0) begin bad++; $display("FAIL mid_err_drop got=%b exp=0", csr_err); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL mid_out_clear got=%h exp=0", out_data); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_minstret();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); idle(); retire = 1'b1;
      if (k == 3) begin
        csr_val = 1'b1; csr_addr = 12'hC02; #1;
        total++; if (csr_rdata !== 32'd2) begin bad++; $display("FAIL minstret_mid got=%h exp=2", csr_rdata); end
      end
    end
    @(negedge clk); idle(); csr_val = 1'b1; csr_addr = 12'hC02; #1;
    total++; if (csr_rdata !== 32'd5) begin bad++; $display("FAIL minstret_final got=%h exp=5", csr_rdata); end
    csr_addr = 12'hC82; #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL minstret_hi got=%h exp=0", csr_rdata); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_sync();
    test_illegal();
    test_back_to_back();
    test_random();
    test_wrap();
    test_reset_mid();
    test_minstret();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
